// File: rtl/password_entry_ctrl.sv
// Keypad-style password controller: five buttons edit a BCD entry, which is
// converted MSD-first to binary and then stored as master or checked against it.
module password_entry_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int VALUE_W      = 14,
    parameter int MAX_ATTEMPTS = 3,
    parameter int LOCK_SECS    = 10
) (
    input  logic                          basys_clk,
    input  logic                          reset,
    input  logic                          btnL,
    input  logic                          btnR,
    input  logic                          btnU,
    input  logic                          btnD,
    input  logic                          btnC,
    input  logic                          mode_set,
    input  logic                          sec_tick,
    output logic [4*NUM_DIGITS-1:0]       digits_out,
    output logic [$clog2(NUM_DIGITS)-1:0] selected_digit,
    output logic [VALUE_W-1:0]            value_out,
    output logic                          busy,
    output logic                          master_valid,
    output logic                          set_done,
    output logic                          match_pulse,
    output logic                          fail_pulse,
    output logic                          locked,
    output logic [3:0]                    attempts_left
);

    localparam int SEL_W = $clog2(NUM_DIGITS);
    localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_DIGITS - 1);
    localparam logic [3:0]       ATT_RELOAD = 4'(MAX_ATTEMPTS);
    localparam logic [7:0]       LOCK_LAST  = 8'(LOCK_SECS - 1);

    typedef enum logic [1:0] {
        EDIT    = 2'd0,
        CONVERT = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t                     state;
    logic [NUM_DIGITS-1:0][3:0] digits;
    logic [NUM_DIGITS-1:0][3:0] digit_up;
    logic [NUM_DIGITS-1:0][3:0] digit_dn;
    logic [4:0]                 btn_now;
    logic [4:0]                 btn_prev;
    logic [4:0]                 btn_edge;
    logic                       act_c;
    logic                       act_l;
    logic                       act_r;
    logic                       act_u;
    logic                       act_d;
    logic [SEL_W-1:0]           conv_cnt;
    logic [SEL_W-1:0]           conv_idx;
    logic [3:0]                 conv_digit;
    logic [VALUE_W-1:0]         acc;
    logic [VALUE_W-1:0]         acc_next;
    logic [VALUE_W-1:0]         master;
    logic                       mode_latched;
    logic [7:0]                 lock_cnt;

    // Bit order {C, L, R, U, D} matches the action priority, MSB first.
    assign btn_now  = {btnC, btnL, btnR, btnU, btnD};
    assign btn_edge = btn_now & ~btn_prev;

    always_comb begin
        act_c = 1'b0;
        act_l = 1'b0;
        act_r = 1'b0;
        act_u = 1'b0;
        act_d = 1'b0;
        if (btn_edge[4])      act_c = 1'b1;
        else if (btn_edge[3]) act_l = 1'b1;
        else if (btn_edge[2]) act_r = 1'b1;
        else if (btn_edge[1]) act_u = 1'b1;
        else if (btn_edge[0]) act_d = 1'b1;
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_up[gi] = (digits[gi] >= 4'd9) ? 4'd0 : digits[gi] + 4'd1;
            assign digit_dn[gi] = (digits[gi] == 4'd0 || digits[gi] > 4'd9) ? 4'd9
                                                                             : digits[gi] - 4'd1;
        end
    endgenerate

    // Horner step, MSD first: conv_cnt = 0 consumes the top digit.
    assign conv_idx   = LAST_SEL - conv_cnt;
    assign conv_digit = digits[conv_idx];
    assign acc_next   = (acc << 3) + (acc << 1) + VALUE_W'(conv_digit);

    assign digits_out = digits;

    always_ff @(posedge basys_clk or posedge reset) begin
        if (reset) begin
            state          <= EDIT;
            digits         <= '0;
            selected_digit <= '0;
            value_out      <= '0;
            master         <= '0;
            master_valid   <= 1'b0;
            attempts_left  <= ATT_RELOAD;
            lock_cnt       <= '0;
            busy           <= 1'b0;
            locked         <= 1'b0;
            set_done       <= 1'b0;
            match_pulse    <= 1'b0;
            fail_pulse     <= 1'b0;
            btn_prev       <= '0;
            conv_cnt       <= '0;
            acc            <= '0;
            mode_latched   <= 1'b0;
        end else begin
            set_done    <= 1'b0;
            match_pulse <= 1'b0;
            fail_pulse  <= 1'b0;
            // Edge history tracks in every state so presses in CONVERT/LOCKED are dropped.
            btn_prev    <= btn_now;

            case (state)
                EDIT: begin
                    if (act_c) begin
                        mode_latched <= mode_set;
                        acc          <= '0;
                        conv_cnt     <= '0;
                        busy         <= 1'b1;
                        state        <= CONVERT;
                    end else if (act_l) begin
                        selected_digit <= (selected_digit == LAST_SEL) ? '0
                                                                       : selected_digit + 1'b1;
                    end else if (act_r) begin
                        selected_digit <= (selected_digit == '0) ? LAST_SEL
                                                                 : selected_digit - 1'b1;
                    end else if (act_u) begin
                        digits[selected_digit] <= digit_up[selected_digit];
                    end else if (act_d) begin
                        digits[selected_digit] <= digit_dn[selected_digit];
                    end
                end

                CONVERT: begin
                    acc <= acc_next;
                    if (conv_cnt == LAST_SEL) begin
                        busy           <= 1'b0;
                        value_out      <= acc_next;
                        digits         <= '0;
                        selected_digit <= '0;
                        conv_cnt       <= '0;
                        state          <= EDIT;
                        if (mode_latched) begin
                            master       <= acc_next;
                            master_valid <= 1'b1;
                            set_done     <= 1'b1;
                        end else if (master_valid && acc_next == master) begin
                            match_pulse   <= 1'b1;
                            attempts_left <= ATT_RELOAD;
                        end else begin
                            fail_pulse    <= 1'b1;
                            attempts_left <= attempts_left - 4'd1;
                            if (attempts_left <= 4'd1) begin
                                locked   <= 1'b1;
                                lock_cnt <= '0;
                                state    <= LOCKED;
                            end
                        end
                    end else begin
                        conv_cnt <= conv_cnt + 1'b1;
                    end
                end

                LOCKED: begin
                    if (sec_tick) begin
                        if (lock_cnt == LOCK_LAST) begin
                            lock_cnt      <= '0;
                            locked        <= 1'b0;
                            attempts_left <= ATT_RELOAD;
                            state         <= EDIT;
                        end else begin
                            lock_cnt <= lock_cnt + 8'd1;
                        end
                    end
                end

                default: state <= EDIT;
            endcase
        end
    end

endmodule

// File: tb/tb_password_entry_ctrl.sv
// Directed bench: a 4-digit and a 6-digit controller, result strobes checked
// by a scoreboard monitor, static outputs checked inline.
module tb_password_entry_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       mode_set;
    logic       sec_tick;
    logic [1:0] bl, br, bu, bd, bc;

    logic [15:0] digits_a;
    logic [1:0]  sel_a;
    logic [13:0] value_a;
    logic        busy_a, mv_a, sd_a, mp_a, fp_a, locked_a;
    logic [3:0]  att_a;

    logic [23:0] digits_b;
    logic [2:0]  sel_b;
    logic [19:0] value_b;
    logic        busy_b, mv_b, sd_b, mp_b, fp_b, locked_b;
    logic [3:0]  att_b;

    password_entry_ctrl dut_a (
        .basys_clk(clk), .reset(reset),
        .btnL(bl[0]), .btnR(br[0]), .btnU(bu[0]), .btnD(bd[0]), .btnC(bc[0]),
        .mode_set(mode_set), .sec_tick(sec_tick),
        .digits_out(digits_a), .selected_digit(sel_a), .value_out(value_a),
        .busy(busy_a), .master_valid(mv_a), .set_done(sd_a),
        .match_pulse(mp_a), .fail_pulse(fp_a), .locked(locked_a),
        .attempts_left(att_a)
    );

    password_entry_ctrl #(.NUM_DIGITS(6), .VALUE_W(20)) dut_b (
        .basys_clk(clk), .reset(reset),
        .btnL(bl[1]), .btnR(br[1]), .btnU(bu[1]), .btnD(bd[1]), .btnC(bc[1]),
        .mode_set(mode_set), .sec_tick(sec_tick),
        .digits_out(digits_b), .selected_digit(sel_b), .value_out(value_b),
        .busy(busy_b), .master_valid(mv_b), .set_done(sd_b),
        .match_pulse(mp_b), .fail_pulse(fp_b), .locked(locked_b),
        .attempts_left(att_b)
    );

    // kind: 0 = set_done, 1 = match_pulse, 2 = fail_pulse
    typedef struct {
        int dut;
        int kind;
        int value;
        int att;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam int K_SET = 0, K_MATCH = 1, K_FAIL = 2;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic mon(input int idx, input logic s, input logic m, input logic f,
                       input int val, input int att);
        exp_t e;
        int   kind;
        if (s | m | f) begin
            checks++;
            kind = s ? K_SET : (m ? K_MATCH : K_FAIL);
            if (int'(s) + int'(m) + int'(f) != 1) begin
                errors++;
                $display("FAIL strobe_exclusive dut%0d set=%0b match=%0b fail=%0b", idx, s, m, f);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe dut%0d kind=%0d value=%0d", idx, kind, val);
            end else begin
                e = sb.pop_front();
                if (e.dut != idx || e.kind != kind || e.value != val || e.att != att) begin
                    errors++;
                    $display("FAIL result dut%0d actual kind=%0d value=%0d att=%0d expected dut%0d kind=%0d value=%0d att=%0d",
                             idx, kind, val, att, e.dut, e.kind, e.value, e.att);
                end else begin
                    $display("result dut%0d kind=%0d value=%0d att=%0d ok", idx, kind, val, att);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon(0, sd_a, mp_a, fp_a, int'(value_a), int'(att_a));
            mon(1, sd_b, mp_b, fp_b, int'(value_b), int'(att_b));
        end
    end

    function automatic logic busy_of(input int w);
        return (w != 0) ? busy_b : busy_a;
    endfunction

    function automatic int digits_of(input int w);
        return (w != 0) ? int'(digits_b) : int'(digits_a);
    endfunction

    function automatic int sel_of(input int w);
        return (w != 0) ? int'(sel_b) : int'(sel_a);
    endfunction

    // mask = {C, L, R, U, D}
    task automatic press(input int w, input logic [4:0] m);
        @(posedge clk); #1;
        bc[w] = m[4]; bl[w] = m[3]; br[w] = m[2]; bu[w] = m[1]; bd[w] = m[0];
        @(posedge clk); #1;
        bc[w] = 1'b0; bl[w] = 1'b0; br[w] = 1'b0; bu[w] = 1'b0; bd[w] = 1'b0;
    endtask

    task automatic enter_value(input int w, input int n, input int val);
        int v = val;
        for (int i = 0; i < n; i++) begin
            repeat (v % 10) press(w, 5'b00010);
            press(w, 5'b01000);
            v = v / 10;
        end
    endtask

    task automatic do_convert(input int w, input logic mode, input int kind,
                              input int val, input int att, input int n);
        int cnt = 0;
        exp_t e;
        e.dut = w; e.kind = kind; e.value = val; e.att = att;
        mode_set = mode;
        sb.push_back(e);
        press(w, 5'b10000);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy_of(w)) cnt++;
            else break;
        end
        chk("busy_cycles", cnt, n);
        chk("digits_cleared", digits_of(w), 0);
        chk("sel_cleared", sel_of(w), 0);
        @(posedge clk); #1;
        chk("scoreboard_popped", sb.size(), 0);
    endtask

    task automatic tick();
        @(posedge clk); #1 sec_tick = 1'b1;
        @(posedge clk); #1 sec_tick = 1'b0;
    endtask

    task automatic reset_and_check();
        @(negedge clk); #1 reset = 1'b1;
        #1;
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_locked", int'(locked_a), 0);
        chk("rst_value", int'(value_a), 0);
        chk("rst_digits", int'(digits_a), 0);
        chk("rst_sel", int'(sel_a), 0);
        chk("rst_master_valid", int'(mv_a), 0);
        chk("rst_attempts", int'(att_a), 3);
        chk("rst_strobes", int'(sd_a | mp_a | fp_a), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; mode_set = 1'b0; sec_tick = 1'b0;
        bl = '0; br = '0; bu = '0; bd = '0; bc = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("init_digits", int'(digits_a), 0);
        chk("init_sel", int'(sel_a), 0);
        chk("init_value", int'(value_a), 0);
        chk("init_busy", int'(busy_a), 0);
        chk("init_master_valid", int'(mv_a), 0);
        chk("init_attempts", int'(att_a), 3);
        chk("init_locked", int'(locked_a), 0);

        // Wrap-around and priority
        press(0, 5'b00001);
        chk("d_wrap_0_to_9", int'(digits_a), 16'h0009);
        press(0, 5'b00100);
        chk("r_wrap_0_to_3", int'(sel_a), 3);
        press(0, 5'b01010);
        chk("lu_sel_only", int'(sel_a), 0);
        chk("lu_digits_same", int'(digits_a), 16'h0009);
        press(0, 5'b00010);
        chk("u_wrap_9_to_0", int'(digits_a), 0);

        // A held button acts once
        @(posedge clk); #1 bu[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1 bu[0] = 1'b0;
        chk("hold_one_action", int'(digits_a), 1);
        press(0, 5'b00001);

        // Set master 23
        repeat (3) press(0, 5'b00010);
        press(0, 5'b01000);
        repeat (2) press(0, 5'b00010);
        chk("entry_23", int'(digits_a), 16'h0023);
        do_convert(0, 1'b1, K_SET, 23, 3, 4);
        chk("value_23", int'(value_a), 23);
        chk("master_valid_set", int'(mv_a), 1);

        // Master 1234, then a matching check
        enter_value(0, 4, 1234);
        chk("entry_1234", int'(digits_a), 16'h1234);
        do_convert(0, 1'b1, K_SET, 1234, 3, 4);
        enter_value(0, 4, 1234);
        do_convert(0, 1'b0, K_MATCH, 1234, 3, 4);

        // Three failures lead to lockout
        enter_value(0, 4, 1111);
        do_convert(0, 1'b0, K_FAIL, 1111, 2, 4);
        do_convert(0, 1'b0, K_FAIL, 0, 1, 4);
        enter_value(0, 4, 5);
        do_convert(0, 1'b0, K_FAIL, 5, 0, 4);
        chk("locked_after_3", int'(locked_a), 1);
        chk("attempts_zero", int'(att_a), 0);
        press(0, 5'b00010);
        chk("locked_ignores_u", int'(digits_a), 0);
        press(0, 5'b10000);
        @(negedge clk);
        chk("locked_ignores_c", int'(busy_a), 0);
        repeat (9) tick();
        chk("still_locked_9", int'(locked_a), 1);
        tick();
        chk("unlocked_10", int'(locked_a), 0);
        chk("attempts_reload", int'(att_a), 3);
        enter_value(0, 4, 1234);
        do_convert(0, 1'b0, K_MATCH, 1234, 3, 4);

        // Reset mid-CONVERT
        enter_value(0, 2, 12);
        mode_set = 1'b0;
        press(0, 5'b10000);
        @(negedge clk);
        chk("busy_before_reset", int'(busy_a), 1);
        reset_and_check();
        repeat (6) @(posedge clk);
        #1 chk("no_strobe_after_conv_reset", sb.size(), 0);

        // Reset mid-LOCKED (no master, so every check fails)
        do_convert(0, 1'b0, K_FAIL, 0, 2, 4);
        do_convert(0, 1'b0, K_FAIL, 0, 1, 4);
        do_convert(0, 1'b0, K_FAIL, 0, 0, 4);
        repeat (3) tick();
        chk("locked_before_reset", int'(locked_a), 1);
        reset_and_check();

        // Six-digit instance
        enter_value(1, 6, 999999);
        chk("entry_999999", digits_b, 24'h999999);
        do_convert(1, 1'b1, K_SET, 999999, 3, 6);
        chk("value_999999", int'(value_b), 999999);

        repeat (3) @(posedge clk);
        #1 chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
